// File: rtl/ex_ls_pkg.sv
// Shared load/store definitions: op encodings, tag/register types, FSM states and
// size/sign decode helpers used by ex_ls and ls_extend.
package ex_ls_pkg;

    localparam int TAG_W = 4;
    localparam int REG_W = 5;

    typedef logic [TAG_W-1:0] regtag_t;
    typedef logic [REG_W-1:0] regaddr_t;
    typedef logic [31:0]      word_t;

    // Tag value meaning "operand data is valid"
    localparam regtag_t UNLOCKED = '0;

    typedef enum logic [2:0] {
        LS_LB, LS_LH, LS_LW, LS_LBU, LS_LHU, LS_SB, LS_SH, LS_SW
    } sinst_t;

    typedef enum logic [2:0] {
        IDLE, REQ, XFER, WAIT, DONE
    } state_t;

    function automatic logic is_store(sinst_t op);
        return (op == LS_SB) || (op == LS_SH) || (op == LS_SW);
    endfunction

    // Index of the last byte moved (transfer size minus one)
    function automatic logic [1:0] last_idx(sinst_t op);
        case (op)
            LS_LB, LS_LBU, LS_SB: return 2'd0;
            LS_LH, LS_LHU, LS_SH: return 2'd1;
            default:              return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/ex_ls_extend.sv
// Combinational load-result extension: LB/LH sign-extend, LBU/LHU zero-extend,
// LW passes the raw word through. Zero latency, no flow control.
module ls_extend
    import ex_ls_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  sinst_t            op,
    input  logic [XLEN-1:0]   raw,
    output logic [XLEN-1:0]   ext
);

    always_comb begin
        ext = raw;
        case (op)
            LS_LB:   ext = {{(XLEN-8){raw[7]}},   raw[7:0]};
            LS_LBU:  ext = {{(XLEN-8){1'b0}},     raw[7:0]};
            LS_LH:   ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
            LS_LHU:  ext = {{(XLEN-16){1'b0}},    raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/ex_ls.sv
// Byte-serial load/store unit behind the LS station; loads finish n+1 cycles after grant,
// stores n. Pauses on dropped grant, freezes completely while rdy=0.
module ex_ls
    import ex_ls_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               ls_busy_in,
    input  sinst_t             ls_op_in,
    input  logic [XLEN-1:0]    ls_offset_in,
    input  regtag_t            ls_tagx_in,
    input  regtag_t            ls_tagy_in,
    input  regtag_t            ls_tagw_in,
    input  logic [XLEN-1:0]    ls_datax_in,
    input  logic [XLEN-1:0]    ls_datay_in,
    input  regaddr_t           ls_target_in,
    output logic               mem_req,
    input  logic               mem_gnt,
    output logic [ADDR_W-1:0]  mem_a,
    output logic               mem_wr,
    output logic [7:0]         mem_dout,
    input  logic [7:0]         mem_din,
    output logic               en_ls,
    output logic               busy_ls,
    output logic [XLEN-1:0]    ls_data,
    output regtag_t            ls_tag_out,
    output regaddr_t           ls_target_out
);

    state_t             state_q, state_d;
    sinst_t             op_q, op_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]    datay_q, datay_d;
    regtag_t            tagw_q, tagw_d;
    regaddr_t           target_q, target_d;
    logic [1:0]         last_q, last_d;
    logic [1:0]         i_q, i_d;
    logic               pend_q, pend_d;
    logic [1:0]         pidx_q, pidx_d;
    logic [XLEN-1:0]    raw_q, raw_d;
    logic [ADDR_W-1:0]  mem_a_q, mem_a_d;
    logic [7:0]         mem_dout_q, mem_dout_d;
    logic               en_ls_q, en_ls_d;
    logic [XLEN-1:0]    ls_data_q, ls_data_d;
    regtag_t            tag_out_q, tag_out_d;
    regaddr_t           target_out_q, target_out_d;

    logic [XLEN-1:0]    sum_w;
    logic [ADDR_W-1:0]  xfer_a;
    logic [7:0]         xfer_dout;
    logic [XLEN-1:0]    ext_w;
    logic               ready_w;
    logic               finish;

    assign sum_w     = ls_datax_in + ls_offset_in;
    assign xfer_a    = addr_q + ADDR_W'(i_q);
    assign xfer_dout = datay_q[{i_q, 3'b000} +: 8];
    assign ready_w   = ls_busy_in && (ls_tagx_in == UNLOCKED) &&
                       (!is_store(ls_op_in) || (ls_tagy_in == UNLOCKED));

    // Address/data are live during XFER and hold their last value elsewhere
    assign mem_a    = (state_q == XFER) ? xfer_a    : mem_a_q;
    assign mem_dout = (state_q == XFER) ? xfer_dout : mem_dout_q;
    assign mem_wr   = (state_q == XFER) && is_store(op_q) && mem_gnt && rdy;
    assign mem_req  = (state_q == REQ) || (state_q == XFER) || (state_q == WAIT);
    assign busy_ls  = ls_busy_in && (state_q != DONE);

    assign en_ls         = en_ls_q;
    assign ls_data       = ls_data_q;
    assign ls_tag_out    = tag_out_q;
    assign ls_target_out = target_out_q;

    // Read data arrives one cycle after its address; merge it before extension
    always_comb begin
        raw_d = raw_q;
        if (rdy && pend_q) begin
            raw_d[{pidx_q, 3'b000} +: 8] = mem_din;
        end
    end

    ls_extend #(.XLEN(XLEN)) u_ext (
        .op  (op_q),
        .raw (raw_d),
        .ext (ext_w)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        datay_d      = datay_q;
        tagw_d       = tagw_q;
        target_d     = target_q;
        last_d       = last_q;
        i_d          = i_q;
        pend_d       = pend_q;
        pidx_d       = pidx_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        en_ls_d      = en_ls_q;
        ls_data_d    = ls_data_q;
        tag_out_d    = tag_out_q;
        target_out_d = target_out_q;
        finish       = 1'b0;

        if (rdy) begin
            pend_d  = 1'b0;
            en_ls_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (ready_w) begin
                        op_d     = ls_op_in;
                        addr_d   = sum_w[ADDR_W-1:0];
                        datay_d  = ls_datay_in;
                        tagw_d   = ls_tagw_in;
                        target_d = ls_target_in;
                        last_d   = last_idx(ls_op_in);
                        state_d  = REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        i_d     = 2'd0;
                        state_d = XFER;
                    end
                end
                XFER: begin
                    mem_a_d    = xfer_a;
                    mem_dout_d = xfer_dout;
                    if (mem_gnt) begin
                        pend_d = !is_store(op_q);
                        pidx_d = i_q;
                        if (i_q == last_q) begin
                            state_d = is_store(op_q) ? DONE : WAIT;
                            finish  = is_store(op_q);
                        end else begin
                            i_d = i_q + 2'd1;
                        end
                    end
                end
                WAIT: begin
                    state_d = DONE;
                    finish  = 1'b1;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (finish) begin
                en_ls_d      = 1'b1;
                ls_data_d    = is_store(op_q) ? '0 : ext_w;
                tag_out_d    = tagw_q;
                target_out_d = is_store(op_q) ? '0 : target_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= LS_LB;
            addr_q       <= '0;
            datay_q      <= '0;
            tagw_q       <= UNLOCKED;
            target_q     <= '0;
            last_q       <= '0;
            i_q          <= '0;
            pend_q       <= 1'b0;
            pidx_q       <= '0;
            raw_q        <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= '0;
            en_ls_q      <= 1'b0;
            ls_data_q    <= '0;
            tag_out_q    <= UNLOCKED;
            target_out_q <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            datay_q      <= datay_d;
            tagw_q       <= tagw_d;
            target_q     <= target_d;
            last_q       <= last_d;
            i_q          <= i_d;
            pend_q       <= pend_d;
            pidx_q       <= pidx_d;
            raw_q        <= raw_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            en_ls_q      <= en_ls_d;
            ls_data_q    <= ls_data_d;
            tag_out_q    <= tag_out_d;
            target_out_q <= target_out_d;
        end
    end

endmodule

// File: tb/tb_ex_ls.sv
// Directed bench for ex_ls: byte-addressed memory/arbiter model plus hand-computed expectations.
module tb_ex_ls;
    import ex_ls_pkg::*;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        ls_busy_in;
    sinst_t      ls_op_in;
    logic [31:0] ls_offset_in, ls_datax_in, ls_datay_in;
    regtag_t     ls_tagx_in, ls_tagy_in, ls_tagw_in;
    regaddr_t    ls_target_in;
    logic        mem_req, mem_gnt, mem_wr;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout, mem_din;
    logic        en_ls, busy_ls;
    logic [31:0] ls_data;
    regtag_t     ls_tag_out;
    regaddr_t    ls_target_out;

    logic        gnt_allow;
    logic [7:0]  mem  [0:4095];
    logic [7:0]  wmem [0:4095];
    int          wr_cnt = 0;
    int          wr_base;
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #5 clk = ~clk;

    assign mem_gnt = mem_req & gnt_allow;

    // Arbiter + memory: reads return next cycle, frozen (re-presented) while rdy=0
    always @(posedge clk) begin
        if (rdy && mem_req && mem_gnt) begin
            if (mem_wr) begin
                wmem[mem_a[11:0]] <= mem_dout;
                wr_cnt            <= wr_cnt + 1;
            end else begin
                mem_din <= mem[mem_a[11:0]];
            end
        end
    end

    ex_ls #(.ADDR_W(32), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .ls_busy_in    (ls_busy_in),
        .ls_op_in      (ls_op_in),
        .ls_offset_in  (ls_offset_in),
        .ls_tagx_in    (ls_tagx_in),
        .ls_tagy_in    (ls_tagy_in),
        .ls_tagw_in    (ls_tagw_in),
        .ls_datax_in   (ls_datax_in),
        .ls_datay_in   (ls_datay_in),
        .ls_target_in  (ls_target_in),
        .mem_req       (mem_req),
        .mem_gnt       (mem_gnt),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
        .en_ls         (en_ls),
        .busy_ls       (busy_ls),
        .ls_data       (ls_data),
        .ls_tag_out    (ls_tag_out),
        .ls_target_out (ls_target_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input sinst_t op, input logic [31:0] base, input logic [31:0] off,
                         input regtag_t tx, input regtag_t ty, input regtag_t tw,
                         input logic [31:0] dy, input regaddr_t tgt);
        ls_busy_in   = 1'b1;
        ls_op_in     = op;
        ls_datax_in  = base;
        ls_offset_in = off;
        ls_tagx_in   = tx;
        ls_tagy_in   = ty;
        ls_tagw_in   = tw;
        ls_datay_in  = dy;
        ls_target_in = tgt;
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
        mem[12'h104] = 8'h11; mem[12'h105] = 8'h22; mem[12'h106] = 8'h33; mem[12'h107] = 8'h44;
        mem[12'h200] = 8'h80;
        mem[12'h500] = 8'hA1; mem[12'h501] = 8'hB2; mem[12'h502] = 8'hC3; mem[12'h503] = 8'hD4;

        rst = 1'b1; rdy = 1'b1; gnt_allow = 1'b1;
        issue(LS_LB, 32'h0, 32'h0, UNLOCKED, UNLOCKED, UNLOCKED, 32'h0, 5'd0);
        ls_busy_in = 1'b0;
        step(); step();
        check("rst_req",    32'(mem_req), 0);
        check("rst_wr",     32'(mem_wr), 0);
        check("rst_a",      mem_a, 0);
        check("rst_dout",   32'(mem_dout), 0);
        check("rst_en",     32'(en_ls), 0);
        check("rst_data",   ls_data, 0);
        check("rst_tag",    32'(ls_tag_out), 32'(UNLOCKED));
        check("rst_target", 32'(ls_target_out), 0);
        rst = 1'b0;

        // 1: LW 0x100+4, grant held
        issue(LS_LW, 32'h100, 32'd4, UNLOCKED, 4'd9, 4'd3, 32'h0, 5'd7);
        step();
        check("t1_req", 32'(mem_req), 1);
        check("t1_busy", 32'(busy_ls), 1);
        step();
        check("t1_a0", mem_a, 32'h104);
        check("t1_wr", 32'(mem_wr), 0);
        for (int k = 1; k < 4; k++) begin
            step();
            check("t1_a", mem_a, 32'h104 + 32'(k));
        end
        step();
        check("t1_wait_en", 32'(en_ls), 0);
        check("t1_wait_req", 32'(mem_req), 1);
        step();
        check("t1_en", 32'(en_ls), 1);
        check("t1_data", ls_data, 32'h44332211);
        check("t1_tag", 32'(ls_tag_out), 3);
        check("t1_target", 32'(ls_target_out), 7);
        check("t1_busy_done", 32'(busy_ls), 0);
        ls_busy_in = 1'b0;
        step();
        check("t1_en_off", 32'(en_ls), 0);
        check("t1_hold", ls_data, 32'h44332211);
        check("t1_req_off", 32'(mem_req), 0);

        // 2: LB / LBU at 0x201-1
        issue(LS_LB, 32'h201, 32'hFFFF_FFFF, UNLOCKED, UNLOCKED, 4'd4, 32'h0, 5'd8);
        step(); step();
        check("t2_a", mem_a, 32'h200);
        step(); step();
        check("t2_lb_en", 32'(en_ls), 1);
        check("t2_lb", ls_data, 32'hFFFF_FF80);
        ls_busy_in = 1'b0;
        step();
        issue(LS_LBU, 32'h201, 32'hFFFF_FFFF, UNLOCKED, UNLOCKED, 4'd4, 32'h0, 5'd8);
        step(); step(); step(); step();
        check("t2_lbu_en", 32'(en_ls), 1);
        check("t2_lbu", ls_data, 32'h0000_0080);
        ls_busy_in = 1'b0;
        step();

        // 3: SH misaligned across 0x3FF/0x400
        wr_base = wr_cnt;
        issue(LS_SH, 32'h3FF, 32'h0, UNLOCKED, UNLOCKED, 4'd5, 32'h0000_BEEF, 5'd9);
        step(); step();
        check("t3_a0", mem_a, 32'h3FF);
        check("t3_wr0", 32'(mem_wr), 1);
        check("t3_d0", 32'(mem_dout), 32'hEF);
        step();
        check("t3_a1", mem_a, 32'h400);
        check("t3_wr1", 32'(mem_wr), 1);
        check("t3_d1", 32'(mem_dout), 32'hBE);
        step();
        check("t3_en", 32'(en_ls), 1);
        check("t3_data", ls_data, 0);
        check("t3_target", 32'(ls_target_out), 0);
        check("t3_tag", 32'(ls_tag_out), 5);
        check("t3_m3ff", 32'(wmem[12'h3FF]), 32'hEF);
        check("t3_m400", 32'(wmem[12'h400]), 32'hBE);
        check("t3_wrcnt", 32'(wr_cnt - wr_base), 2);
        ls_busy_in = 1'b0;
        step();
        check("t3_en_off", 32'(en_ls), 0);
        check("t3_wr_off", 32'(mem_wr), 0);

        // 4: base tag locked for three cycles
        issue(LS_LW, 32'h104, 32'h0, 4'd6, UNLOCKED, 4'd2, 32'h0, 5'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t4_idle_req", 32'(mem_req), 0);
            check("t4_idle_busy", 32'(busy_ls), 1);
        end
        ls_tagx_in = UNLOCKED;
        step();
        check("t4_req", 32'(mem_req), 1);
        n = 0;
        while (en_ls !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("t4_lat", 32'(n), 6);
        check("t4_data", ls_data, 32'h44332211);
        ls_busy_in = 1'b0;
        step();

        // 5: LW with grant dropped two cycles and one rdy=0 cycle with a read pending
        issue(LS_LW, 32'h500, 32'h0, UNLOCKED, UNLOCKED, 4'd6, 32'h0, 5'd10);
        step(); step();
        check("t5_a0", mem_a, 32'h500);
        step();
        check("t5_a1", mem_a, 32'h501);
        step();
        check("t5_a2", mem_a, 32'h502);
        gnt_allow = 1'b0;
        step();
        check("t5_pause_a", mem_a, 32'h502);
        check("t5_pause_wr", 32'(mem_wr), 0);
        check("t5_pause_req", 32'(mem_req), 1);
        step();
        check("t5_pause_a2", mem_a, 32'h502);
        gnt_allow = 1'b1;
        step();
        check("t5_a3", mem_a, 32'h503);
        rdy = 1'b0;
        step();
        check("t5_frz_a", mem_a, 32'h503);
        check("t5_frz_en", 32'(en_ls), 0);
        rdy = 1'b1;
        step();
        check("t5_wait_en", 32'(en_ls), 0);
        step();
        check("t5_en", 32'(en_ls), 1);
        check("t5_data", ls_data, 32'hD4C3B2A1);
        check("t5_tag", 32'(ls_tag_out), 6);
        ls_busy_in = 1'b0;
        step();

        // 6: SW waits on store-data tag, then reset mid-transfer
        issue(LS_SW, 32'h600, 32'h0, UNLOCKED, 4'd7, 4'd1, 32'hCAFE_BABE, 5'd4);
        step();
        check("t6_tagy_req", 32'(mem_req), 0);
        ls_tagy_in = UNLOCKED;
        step();
        check("t6_req", 32'(mem_req), 1);
        step();
        check("t6_wr0", 32'(mem_wr), 1);
        check("t6_d0", 32'(mem_dout), 32'hBE);
        step();
        check("t6_a1", mem_a, 32'h601);
        check("t6_d1", 32'(mem_dout), 32'hBA);
        rst = 1'b1;
        step();
        check("t6_req", 32'(mem_req), 0);
        check("t6_wr", 32'(mem_wr), 0);
        check("t6_a", mem_a, 0);
        check("t6_dout", 32'(mem_dout), 0);
        check("t6_en", 32'(en_ls), 0);
        check("t6_data", ls_data, 0);
        check("t6_tag", 32'(ls_tag_out), 32'(UNLOCKED));
        check("t6_target", 32'(ls_target_out), 0);
        check("t6_busy", 32'(busy_ls), 1);
        check("t6_partial", 32'(wmem[12'h600]), 32'hBE);
        rst = 1'b0;
        ls_busy_in = 1'b0;
        step();
        check("t6_idle_req", 32'(mem_req), 0);
        check("t6_idle_en", 32'(en_ls), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
